// File: rtl/pixel_fb_sink.sv
// pixel_fb_sink: 3-bit colour frame buffer with a plot write port, a colour
// query read port (collision lookup) and a raster scan-out read port.
// After reset, and on every clear request, the whole frame is filled with
// BG_COLOUR one entry per cycle before plotting is accepted again.
module pixel_fb_sink #(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         H_RES     = 160,
    parameter int         V_RES     = 120
) (
    input  logic       clk,
    input  logic       resetn,

    // pixel write port
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic       plot_ready,

    // frame clear control and status
    input  logic       clear_req,
    output logic       busy,
    output logic       err_oob,

    // colour query port
    input  logic       q_req,
    input  logic [7:0] q_x,
    input  logic [6:0] q_y,
    output logic       q_valid,
    output logic [2:0] q_colour,

    // raster scan-out port
    input  logic       scan_en,
    output logic       scan_valid,
    output logic [2:0] scan_colour,
    output logic [7:0] scan_x,
    output logic [6:0] scan_y,
    output logic       scan_sof,
    output logic       scan_eol
);

    // ------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------
    localparam int              DEPTH     = H_RES * V_RES;
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // True when the coordinate lies inside the visible frame.
    function automatic logic in_frame(input logic [7:0] px, input logic [6:0] py);
        return (int'(px) < H_RES) && (int'(py) < V_RES);
    endfunction

    // Linear address of an in-frame coordinate (row-major, unsigned).
    function automatic logic [AW-1:0] addr_of(input logic [7:0] px, input logic [6:0] py);
        return AW'(py) * AW'(H_RES) + AW'(px);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [AW-1:0]   clr_addr_q;
    logic            busy_q;
    logic            err_oob_q;

    logic [2:0]      fb_mem [DEPTH];

    logic            q_valid_q;
    logic            q_oob_q;
    logic [2:0]      q_rdata_q;

    logic [7:0]      scan_cnt_x_q;
    logic [6:0]      scan_cnt_y_q;
    logic [7:0]      scan_cnt_x_d;
    logic [6:0]      scan_cnt_y_d;

    logic            scan_valid_q;
    logic [7:0]      scan_x_q;
    logic [6:0]      scan_y_q;
    logic            scan_sof_q;
    logic            scan_eol_q;
    logic [2:0]      scan_rdata_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            run;
    logic            plot_acc;
    logic            plot_in;
    logic            scan_fire;
    logic            q_in;
    logic [AW-1:0]   q_rd_addr;
    logic [AW-1:0]   scan_rd_addr;

    assign run       = (state_q == ST_RUN);
    // A clear request takes priority over a plot in the same cycle.
    assign plot_acc  = run & plot & ~clear_req;
    assign plot_in   = in_frame(x, y);
    assign scan_fire = run & scan_en;
    assign q_in      = in_frame(q_x, q_y);
    // Out-of-frame queries still read a legal address; the result is
    // replaced by BG_COLOUR on the response side.
    assign q_rd_addr    = q_in ? addr_of(q_x, q_y) : '0;
    assign scan_rd_addr = addr_of(scan_cnt_x_q, scan_cnt_y_q);

    // ------------------------------------------------------------------
    // Write port mux: clear sweep while clearing, accepted plots in run
    // ------------------------------------------------------------------
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [2:0]      wr_data;

    // Select the single write source for this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr_q;
        wr_data = BG_COLOUR;
        if (resetn) begin
            if (!run) begin
                wr_en = 1'b1;
            end else if (plot_acc && plot_in) begin
                wr_en   = 1'b1;
                wr_addr = addr_of(x, y);
                wr_data = colour;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: CLEAR sweeps every address once, RUN accepts plots
    // ------------------------------------------------------------------
    // Two-state controller with registered busy; the clear address is the
    // sweep pointer and restarts whenever a new clear is requested.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clear_req) begin
                        clr_addr_q <= '0;
                    end else if (clr_addr_q == LAST_ADDR) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b0;
                        clr_addr_q <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_q    <= ST_CLEAR;
                        busy_q     <= 1'b1;
                        clr_addr_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    busy_q     <= 1'b1;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    // Sticky out-of-frame error; only a reset clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_oob_q <= 1'b0;
        end else if (plot_acc && !plot_in) begin
            err_oob_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer array: one write port, two independent read ports.
    // Reads are registered and see the pre-write contents on a collision.
    // ------------------------------------------------------------------
    // Single write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= wr_data;
        end
    end

    // Query read port (no reset: pure data path).
    always_ff @(posedge clk) begin
        q_rdata_q <= fb_mem[q_rd_addr];
    end

    // Scan read port (no reset: pure data path).
    always_ff @(posedge clk) begin
        scan_rdata_q <= fb_mem[scan_rd_addr];
    end

    // ------------------------------------------------------------------
    // Query response
    // ------------------------------------------------------------------
    // Query qualifiers: one-cycle latency, answered in any state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_valid_q <= 1'b0;
            q_oob_q   <= 1'b0;
        end else begin
            q_valid_q <= q_req;
            q_oob_q   <= ~q_in;
        end
    end

    assign q_valid  = q_valid_q;
    assign q_colour = !q_valid_q ? 3'b000 : (q_oob_q ? BG_COLOUR : q_rdata_q);

    // ------------------------------------------------------------------
    // Raster scan
    // ------------------------------------------------------------------
    // Next scan position: pinned to the origin outside RUN (and when a clear
    // is being entered), otherwise advanced in raster order on each tick.
    always_comb begin
        scan_cnt_x_d = scan_cnt_x_q;
        scan_cnt_y_d = scan_cnt_y_q;
        if (!run || clear_req) begin
            scan_cnt_x_d = '0;
            scan_cnt_y_d = '0;
        end else if (scan_en) begin
            if (int'(scan_cnt_x_q) == H_RES - 1) begin
                scan_cnt_x_d = '0;
                if (int'(scan_cnt_y_q) == V_RES - 1) begin
                    scan_cnt_y_d = '0;
                end else begin
                    scan_cnt_y_d = scan_cnt_y_q + 7'd1;
                end
            end else begin
                scan_cnt_x_d = scan_cnt_x_q + 8'd1;
            end
        end
    end

    // Scan position counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scan_cnt_x_q <= '0;
            scan_cnt_y_q <= '0;
        end else begin
            scan_cnt_x_q <= scan_cnt_x_d;
            scan_cnt_y_q <= scan_cnt_y_d;
        end
    end

    // Scan response side-band: position and frame markers of the pixel read
    // on the previous tick, forced to zero when there is no response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scan_valid_q <= 1'b0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_sof_q   <= 1'b0;
            scan_eol_q   <= 1'b0;
        end else if (scan_fire) begin
            scan_valid_q <= 1'b1;
            scan_x_q     <= scan_cnt_x_q;
            scan_y_q     <= scan_cnt_y_q;
            scan_sof_q   <= (scan_cnt_x_q == 8'd0) && (scan_cnt_y_q == 7'd0);
            scan_eol_q   <= (int'(scan_cnt_x_q) == H_RES - 1);
        end else begin
            scan_valid_q <= 1'b0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            scan_sof_q   <= 1'b0;
            scan_eol_q   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign plot_ready  = run & ~clear_req;
    assign busy        = busy_q;
    assign err_oob     = err_oob_q;
    assign scan_valid  = scan_valid_q;
    assign scan_colour = scan_valid_q ? scan_rdata_q : 3'b000;
    assign scan_x      = scan_x_q;
    assign scan_y      = scan_y_q;
    assign scan_sof    = scan_sof_q;
    assign scan_eol    = scan_eol_q;

endmodule
